baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/uart_pkg.sv | 15 +
 rtl/frac_accum.sv | 32 +++
 rtl/baud_tick_gen.sv | 99 +++++++++
 tb/tb_baud_tick_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART timing defaults and width helpers for the baud/oversample tick path.
package uart_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF    = 16;

  // Width of an index over n oversample slots; a single slot still needs one bit.
  function automatic int os_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int OS_W_DEF = os_width(OVS_DEF);

endpackage

// File: rtl/frac_accum.sv
// Fractional-divisor accumulator: adds the active fraction once per oversample tick
// and reports the carry that stretches the following period by one clock.
module frac_accum
  import uart_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (adv) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator: oversample tick, bit tick and an os_tick-aligned
// divisor reload handshake, with resync for receiver start-bit alignment.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int OVS      = OVS_DEF,
  parameter int DEF_INT  = 27,
  parameter int DEF_FRAC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [DIV_W-1:0]         div_int,
  input  logic [FRAC_W-1:0]        div_frac,
  input  logic                     div_load,
  input  logic                     resync,
  output logic                     os_tick,
  output logic                     bit_tick,
  output logic [os_width(OVS)-1:0] os_cnt,
  output logic                     div_ack
);

  localparam int OS_W  = os_width(OVS);
  localparam int CNT_W = DIV_W + 1;

  // Divisors below 2 cannot produce a distinct tick/idle cycle pair.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  last;
  logic              ext;
  logic              carry;
  logic              pending;
  logic              apply;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;

  assign period   = {1'b0, clamp_div(act_int)} + CNT_W'(ext);
  assign last     = period - CNT_W'(1);
  assign os_tick  = reset & en & ~resync & (cnt == last);
  assign bit_tick = os_tick & (os_cnt == OS_W'(OVS - 1));
  assign apply    = os_tick & pending;

  frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk   (clk),
    .reset (reset),
    .clr   (resync),
    .adv   (os_tick),
    .frac  (act_frac),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      ext      <= 1'b0;
      os_cnt   <= '0;
      pending  <= 1'b0;
      div_ack  <= 1'b0;
      act_int  <= DIV_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      sh_int   <= DIV_W'(DEF_INT);
      sh_frac  <= FRAC_W'(DEF_FRAC);
    end else begin
      div_ack <= apply;
      // A load landing on the applying tick re-arms pending for the newer value.
      pending <= div_load | (pending & ~apply);
      if (div_load) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end
      if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      if (resync) begin
        cnt    <= '0;
        ext    <= 1'b0;
        os_cnt <= '0;
      end else if (os_tick) begin
        cnt    <= '0;
        ext    <= carry;
        os_cnt <= os_cnt + OS_W'(1);
      end else if (en) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: expected tick/ack cycles are queued by the
// stimulus thread and retired by a monitor watching the DUT outputs.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick;
  logic        bit_tick;
  logic [3:0]  os_cnt;
  logic        div_ack;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int cyc;
    int osi;
  } tick_t;

  tick_t tick_q[$];
  int    ack_q[$];

  baud_tick_gen #(
    .DIV_W    (16),
    .FRAC_W   (4),
    .OVS      (16),
    .DEF_INT  (27),
    .DEF_FRAC (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .resync   (resync),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .os_cnt   (os_cnt),
    .div_ack  (div_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_ev(input string name, input int got, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tick(input int c, input int o);
    tick_t e;
    e.cyc = c;
    e.osi = o;
    tick_q.push_back(e);
  endtask

  task automatic load(input int t, input int di, input int df);
    goto(t);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    goto(t + 1);
    div_load = 1'b0;
  endtask

  // Monitor: retire queued expectations as the DUT presents ticks and acks.
  always @(negedge clk) begin
    tick_t e;
    int    a;
    if (mon_on) begin
      while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
        e = tick_q.pop_front();
        fail_ev("missed_os_tick", cyc, e.cyc);
      end
      while (ack_q.size() > 0 && ack_q[0] < cyc) begin
        a = ack_q.pop_front();
        fail_ev("missed_div_ack", cyc, a);
      end
      if (os_tick) begin
        if (tick_q.size() == 0) begin
          fail_ev("unexpected_os_tick", cyc, -1);
        end else begin
          e = tick_q.pop_front();
          chk("os_tick_cycle", cyc, e.cyc);
          chk("os_cnt_at_tick", int'(os_cnt), e.osi);
          chk("bit_tick", int'(bit_tick), int'(e.osi == 15));
        end
      end else if (bit_tick) begin
        chk("bit_tick_without_os_tick", int'(bit_tick), 0);
      end
      if (div_ack) begin
        if (ack_q.size() == 0) begin
          fail_ev("unexpected_div_ack", cyc, -1);
        end else begin
          a = ack_q.pop_front();
          chk("div_ack_cycle", cyc, a);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r, s, s2, r2;
    goto(1);
    chk("os_tick_in_reset", int'(os_tick), 0);
    chk("div_ack_in_reset", int'(div_ack), 0);
    goto(3);
    reset = 1'b1;
    r = cyc;
    mon_on = 1'b1;
    chk("reset_os_cnt", int'(os_cnt), 0);
    chk("reset_os_tick", int'(os_tick), 0);
    chk("reset_bit_tick", int'(bit_tick), 0);
    chk("reset_div_ack", int'(div_ack), 0);

    // Default divisor 27: first tick 26 cycles into the count, then every 27.
    for (int k = 0; k < 25; k++) push_tick(r + 26 + 27 * k, k % 16);

    // Resync with cnt=13, os_cnt=9.
    s = r + 688;
    goto(s);
    chk("os_cnt_before_resync", int'(os_cnt), 9);
    resync = 1'b1;
    goto(s + 1);
    resync = 1'b0;
    chk("os_cnt_after_resync", int'(os_cnt), 0);
    for (int k = 0; k < 4; k++) push_tick(s + 27 * (k + 1), k);

    // Resync exactly on the cycle a tick would have fired.
    s2 = s + 135;
    goto(s2);
    resync = 1'b1;
    goto(s2 + 1);
    resync = 1'b0;
    push_tick(s2 + 27, 0);

    // Freeze 50 cycles at cnt=9; a load issued while frozen is still captured.
    goto(s2 + 37);
    en = 1'b0;
    load(s2 + 50, 10, 8);
    goto(s2 + 60);
    chk("os_cnt_frozen", int'(os_cnt), 1);
    chk("os_tick_frozen", int'(os_tick), 0);
    goto(s2 + 87);
    en = 1'b1;
    push_tick(s2 + 104, 1);
    ack_q.push_back(s2 + 105);
    push_tick(s2 + 114, 2);
    push_tick(s2 + 124, 3);
    push_tick(s2 + 135, 4);
    push_tick(s2 + 145, 5);
    push_tick(s2 + 156, 6);
    push_tick(s2 + 166, 7);

    // Two loads before the boundary: only the second takes effect.
    load(s2 + 170, 5, 0);
    load(s2 + 172, 7, 0);
    push_tick(s2 + 177, 8);
    ack_q.push_back(s2 + 178);
    push_tick(s2 + 184, 9);
    push_tick(s2 + 191, 10);
    push_tick(s2 + 198, 11);

    // Divisor 0 clamps to 2.
    load(s2 + 200, 0, 0);
    push_tick(s2 + 205, 12);
    ack_q.push_back(s2 + 206);
    push_tick(s2 + 207, 13);
    push_tick(s2 + 209, 14);
    push_tick(s2 + 211, 15);
    push_tick(s2 + 213, 0);

    // Reset while a load is pending discards it and restores defaults.
    load(s2 + 214, 10, 0);
    reset = 1'b0;
    goto(s2 + 216);
    chk("os_tick_in_reset2", int'(os_tick), 0);
    goto(s2 + 217);
    reset = 1'b1;
    r2 = cyc;
    chk("reset2_os_cnt", int'(os_cnt), 0);
    chk("reset2_div_ack", int'(div_ack), 0);
    push_tick(r2 + 26, 0);
    push_tick(r2 + 53, 1);

    goto(r2 + 70);
    chk("ticks_outstanding", tick_q.size(), 0);
    chk("acks_outstanding", ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
